// File: rtl/sft_seq_pkg.sv
// Shared definitions for the shift-register refresh sequencer and its shift stage:
// sequencer state encoding and the command codes carried on sft_cmd.
package sft_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SWAIT,
      STORE,
      TWAIT,
      OE,
      CLR,
      ACK
   } state_t;

   localparam logic [1:0] CMD_MR    = 2'b00;
   localparam logic [1:0] CMD_SHIFT = 2'b01;
   localparam logic [1:0] CMD_STORE = 2'b10;
   localparam logic [1:0] CMD_OE    = 2'b11;

endpackage

// File: rtl/sft_seq.sv
// Refresh sequencer for NBYTE cascaded 8-bit shift registers: shifts the payload MSB first,
// latches, drives output enable, with a per-command done timeout and a clear-only sequence.
module sft_seq
   import sft_seq_pkg::*;
#(
   parameter int NBYTE  = 4,
   parameter int TO_CYC = 127
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               req_clr,
   input  logic [8*NBYTE-1:0] req_data,
   input  logic               req_oen,
   output logic               busy,
   output logic               ack,
   output logic               err,
   output logic               sft_vld,
   output logic [1:0]         sft_cmd,
   output logic               sft_cmd_oen,
   output logic [7:0]         sft_din,
   input  logic               sft_done
);

   localparam int IW = $clog2(NBYTE) + 1;
   localparam int CW = $clog2(TO_CYC + 1);

   state_t             state;
   logic [8*NBYTE-1:0] data_q;
   logic               oen_q;
   logic [IW-1:0]      idx;
   logic [CW-1:0]      cnt;

   // Byte k of the payload counted from the most-significant end.
   function automatic logic [7:0] byte_at(input logic [8*NBYTE-1:0] d, input logic [IW-1:0] k);
      logic [8*NBYTE-1:0] s;
      s = d << (8 * k);
      return s[8*NBYTE-1 -: 8];
   endfunction

   // NOTE: all state lives in this one clocked block and uses non-blocking assignments,
   // so every branch reads the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         ack         <= 1'b0;
         err         <= 1'b0;
         sft_vld     <= 1'b0;
         sft_cmd     <= CMD_MR;
         sft_cmd_oen <= 1'b1;
         sft_din     <= 8'h00;
         data_q      <= '0;
         oen_q       <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
      end else begin
         // NOTE: strobes default low each cycle so any branch that raises them yields a single-cycle pulse.
         sft_vld <= 1'b0;
         ack     <= 1'b0;
         case (state)
            IDLE, ACK: begin
               if (req_clr) begin
                  state   <= CLR;
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  sft_vld <= 1'b1;
                  sft_cmd <= CMD_MR;
               end else if (req) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  data_q  <= req_data;
                  oen_q   <= req_oen;
                  sft_vld <= 1'b1;
                  sft_cmd <= CMD_SHIFT;
                  sft_din <= byte_at(req_data, IW'(0));
                  idx     <= IW'(1);
                  cnt     <= CW'(1);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            SHIFT, STORE: begin
               state <= (state == SHIFT) ? SWAIT : TWAIT;
               cnt   <= cnt + CW'(1);
            end
            SWAIT, TWAIT: begin
               if (sft_done) begin
                  sft_vld <= 1'b1;
                  cnt     <= CW'(1);
                  if (state == TWAIT) begin
                     state       <= OE;
                     sft_cmd     <= CMD_OE;
                     sft_cmd_oen <= oen_q;
                  end else if (idx == IW'(NBYTE)) begin
                     state   <= STORE;
                     sft_cmd <= CMD_STORE;
                  end else begin
                     state   <= SHIFT;
                     sft_cmd <= CMD_SHIFT;
                     sft_din <= byte_at(data_q, idx);
                     idx     <= idx + IW'(1);
                  end
               end else if (cnt == CW'(TO_CYC)) begin
                  // Counter includes the strobe cycle, so the abort strobe lands TO_CYC cycles after the command.
                  state   <= IDLE;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  sft_vld <= 1'b1;
                  sft_cmd <= CMD_MR;
                  idx     <= '0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            OE, CLR: begin
               state <= ACK;
               busy  <= 1'b0;
               ack   <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sft_seq.sv
// Scoreboard bench for sft_seq: a behavioural timing model queues expected commands and acks,
// a monitor compares every cycle, and a shift-stage model answers commands after a set latency.
module tb_sft_seq;

   localparam int NBYTE  = 4;
   localparam int TO_CYC = 127;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req = 1'b0;
   logic               req_clr = 1'b0;
   logic [8*NBYTE-1:0] req_data = '0;
   logic               req_oen = 1'b0;
   logic               sft_done = 1'b0;
   logic               busy, ack, err, sft_vld, sft_cmd_oen;
   logic [1:0]         sft_cmd;
   logic [7:0]         sft_din;

   sft_seq #(.NBYTE(NBYTE), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .req(req), .req_clr(req_clr), .req_data(req_data),
      .req_oen(req_oen), .busy(busy), .ack(ack), .err(err), .sft_vld(sft_vld),
      .sft_cmd(sft_cmd), .sft_cmd_oen(sft_cmd_oen), .sft_din(sft_din), .sft_done(sft_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] cmd;
      logic [7:0] din;
      logic       oen;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   ack_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Shift-stage model state: done follows a shift/store command after a chosen latency.
   int   lat_shift = 63;
   int   lat_store = 7;
   logic pending = 1'b0;
   int   done_at = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   // Expected command timeline for a refresh accepted in cycle t0.
   task automatic push_refresh(input int t0, input logic [31:0] data, input logic oen,
                               input int ls, input int lt);
      int t;
      logic [7:0] b;
      t = t0 + 1;
      for (int k = 0; k < NBYTE; k++) begin
         b = 8'(data >> (8 * (NBYTE - 1 - k)));
         exp_q.push_back('{cyc: t, cmd: 2'b01, din: b, oen: 1'b0, err: 1'b0});
         if (ls >= TO_CYC) begin
            exp_q.push_back('{cyc: t + TO_CYC, cmd: 2'b00, din: 8'h00, oen: 1'b0, err: 1'b1});
            return;
         end
         t = t + ls + 1;
      end
      exp_q.push_back('{cyc: t, cmd: 2'b10, din: 8'h00, oen: 1'b0, err: 1'b0});
      if (lt >= TO_CYC) begin
         exp_q.push_back('{cyc: t + TO_CYC, cmd: 2'b00, din: 8'h00, oen: 1'b0, err: 1'b1});
         return;
      end
      t = t + lt + 1;
      exp_q.push_back('{cyc: t, cmd: 2'b11, din: 8'h00, oen: oen, err: 1'b0});
      ack_q.push_back(t + 1);
   endtask

   task automatic push_clr(input int t0);
      exp_q.push_back('{cyc: t0 + 1, cmd: 2'b00, din: 8'h00, oen: 1'b0, err: 1'b0});
      ack_q.push_back(t0 + 2);
   endtask

   // All stimulus tasks start and end just after a rising edge.
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) check("wait_idle_bound", busy, 0);
   endtask

   task automatic do_req(input logic [31:0] data, input logic oen, input int ls, input int lt,
                         input logic with_clr, output int t0);
      wait_idle();
      lat_shift = ls;
      lat_store = lt;
      req       = 1'b1;
      req_clr   = with_clr;
      req_data  = data;
      req_oen   = oen;
      t0        = cyc;
      if (with_clr) push_clr(t0);
      else push_refresh(t0, data, oen, ls, lt);
      @(posedge clk); #1;
      req      = 1'b0;
      req_clr  = 1'b0;
      req_data = $urandom;
      req_oen  = ~oen;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ack"}, ack, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_vld"}, sft_vld, 0);
      check({tag, "_cmd"}, sft_cmd, 0);
      check({tag, "_oen"}, sft_cmd_oen, 1);
      check({tag, "_din"}, sft_din, 0);
   endtask

   // Monitor and shift-stage command capture.
   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         mon_e = exp_q.pop_front();
         check("cmd_strobe", sft_vld, 1);
         check("cmd_code", sft_cmd, mon_e.cmd);
         if (mon_e.cmd == 2'b01) check("cmd_byte", sft_din, mon_e.din);
         if (mon_e.cmd == 2'b11) check("cmd_oen", sft_cmd_oen, mon_e.oen);
         check("err_flag", err, mon_e.err);
      end else begin
         check("no_cmd_strobe", sft_vld, 0);
      end
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
         void'(ack_q.pop_front());
         check("ack_pulse", ack, 1);
      end else begin
         check("no_ack_pulse", ack, 0);
      end
      if (rst) begin
         pending = 1'b0;
      end else if (sft_vld) begin
         if (sft_cmd == 2'b01 || sft_cmd == 2'b10) begin
            pending = 1'b1;
            done_at = cyc + ((sft_cmd == 2'b01) ? lat_shift : lat_store);
         end else if (sft_cmd == 2'b00) begin
            pending = 1'b0;
         end
      end
   end

   // Shift-stage done driver.
   initial forever begin
      @(posedge clk); #1;
      sft_done = pending && (cyc == done_at);
      if (sft_done) pending = 1'b0;
   end

   initial begin
      int t0;
      int r;
      int n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reference refresh: bytes A5,5A,0F,F0 at T+1/65/129/193, store T+257, OE T+265, ack T+266.
      do_req(32'hA55A0FF0, 1'b0, 63, 7, 1'b0, t0);

      // Clear-only sequence with busy high only in T+1.
      wait_idle();
      req_clr = 1'b1;
      t0      = cyc;
      push_clr(t0);
      @(posedge clk); #1;
      req_clr = 1'b0;
      @(negedge clk);
      check("clr_busy_t1", busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("clr_busy_t2", busy, 0);
      @(posedge clk); #1;

      // req and req_clr together: clear wins.
      do_req($urandom, 1'b1, 10, 3, 1'b1, t0);

      // Requests while busy are dropped.
      do_req($urandom, 1'b1, 20, 5, 1'b0, t0);
      repeat (4) begin @(posedge clk); #1; end
      req = 1'b1;
      req_data = $urandom;
      repeat (3) begin @(posedge clk); #1; end
      req = 1'b0;
      req_clr = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      req_clr = 1'b0;

      // Done held low after the first shift: timeout, sticky err, cleared by the next request.
      do_req($urandom, 1'b1, 100000, 5, 1'b0, t0);
      wait_idle();
      repeat (3) begin @(posedge clk); #1; end
      check("err_sticky", err, 1);
      do_req($urandom, 1'b0, 4, 2, 1'b0, t0);

      // Timeout boundaries on shift and store waits.
      do_req($urandom, 1'b1, TO_CYC - 1, TO_CYC - 1, 1'b0, t0);
      do_req($urandom, 1'b0, 5, TO_CYC, 1'b0, t0);
      do_req($urandom, 1'b1, TO_CYC, 5, 1'b0, t0);

      // Randomized mix, including back-to-back acceptance in the ACK cycle.
      for (int i = 0; i < 25; i++) begin
         r = $urandom_range(0, 5);
         if (r == 0) begin
            req = $urandom_range(0, 1);
            do_req($urandom, 1'b0, 1, 1, 1'b1, t0);
         end else begin
            do_req($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 40),
                   $urandom_range(1, 20), 1'b0, t0);
         end
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end

      // Reset in cycle T+100 of a refresh.
      do_req(32'h12345678, 1'b1, 63, 7, 1'b0, t0);
      while (cyc < t0 + 100) begin @(posedge clk); #1; end
      rst = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > t0 + 100) void'(exp_q.pop_back());
      ack_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_values("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (150) begin @(posedge clk); #1; end

      do_req($urandom, 1'b1, 3, 3, 1'b0, t0);

      n = 0;
      while ((exp_q.size() > 0 || ack_q.size() > 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("exp_cmds_drained", exp_q.size(), 0);
      check("exp_acks_drained", ack_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
